// File: rtl/coproc_result_gate.sv
// Commit-gated result path between a coprocessor and the core-side CV-X-IF result port.
// Optional direct load of committed results into the output register: COPROC_RESULT_GATE_BYPASS_EN.
module coproc_result_gate #(
  parameter int X_ID_WIDTH  = 4,
  parameter int X_RFW_WIDTH = 32,
  parameter int XLEN        = 32,
  parameter int DEPTH       = 4
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        issue_valid,
  input  logic                        issue_ready,
  input  logic                        issue_resp_accept,
  input  logic                        issue_resp_writeback,
  input  logic [X_ID_WIDTH-1:0]       issue_req_id,
  input  logic                        commit_valid,
  input  logic [X_ID_WIDTH-1:0]       commit_id,
  input  logic                        commit_kill,
  input  logic                        cp_result_valid,
  output logic                        cp_result_ready,
  input  logic [X_ID_WIDTH-1:0]       cp_result_id,
  input  logic [X_RFW_WIDTH-1:0]      cp_result_data,
  input  logic [4:0]                  cp_result_rd,
  input  logic [X_RFW_WIDTH/XLEN-1:0] cp_result_we,
  input  logic                        cp_result_exc,
  input  logic [5:0]                  cp_result_exccode,
  output logic                        result_valid,
  input  logic                        result_ready,
  output logic [X_ID_WIDTH-1:0]       result_id,
  output logic [X_RFW_WIDTH-1:0]      result_data,
  output logic [4:0]                  result_rd,
  output logic [X_RFW_WIDTH/XLEN-1:0] result_we,
  output logic                        result_exc,
  output logic [5:0]                  result_exccode,
  output logic [X_ID_WIDTH:0]         pending_count,
  output logic                        err_o
);

  localparam int NUM_IDS = 2 ** X_ID_WIDTH;
  localparam int WE_W    = X_RFW_WIDTH / XLEN;
  localparam int AW      = $clog2(DEPTH);

  typedef enum logic [1:0] {
    ST_FREE      = 2'd0,
    ST_ISSUED    = 2'd1,
    ST_COMMITTED = 2'd2,
    ST_KILLED    = 2'd3
  } id_state_e;

  typedef struct packed {
    logic [X_ID_WIDTH-1:0]  id;
    logic [X_RFW_WIDTH-1:0] data;
    logic [4:0]             rd;
    logic [WE_W-1:0]        we;
    logic                   exc;
    logic [5:0]             exccode;
  } res_t;

  id_state_e           tbl_q [NUM_IDS];
  id_state_e           tbl_d [NUM_IDS];
  res_t                mem_q [DEPTH];
  res_t                mem_d [DEPTH];
  logic [AW:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic                out_valid_q, out_valid_d;
  res_t                out_q, out_d;
  logic [X_ID_WIDTH:0] pending_q, pending_d;
  logic                err_q, err_d;

  res_t      cp_res_s, head_s, load_s;
  id_state_e head_st_s, in_st_s;
  logic      track_s, cp_wr_s, out_room_s, bypass_s, load_s_en, err_set_s;
  logic      fifo_full_s, fifo_empty_s;

  assign cp_res_s     = {cp_result_id, cp_result_data, cp_result_rd, cp_result_we,
                         cp_result_exc, cp_result_exccode};
  assign fifo_empty_s = (wr_ptr_q == rd_ptr_q);
  assign fifo_full_s  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
  assign track_s      = issue_valid & issue_ready & issue_resp_accept & issue_resp_writeback;
  assign out_room_s   = ~out_valid_q | result_ready;
  assign cp_wr_s      = cp_result_valid & ~fifo_full_s;
  assign head_s       = mem_q[rd_ptr_q[AW-1:0]];

  // Next-state: ID table, FIFO, output register, pending count and error flag
  always_comb begin
    tbl_d       = tbl_q;
    mem_d       = mem_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    out_valid_d = out_valid_q;
    out_d       = out_q;
    err_set_s   = 1'b0;
    load_s_en   = 1'b0;
    load_s      = head_s;
    bypass_s    = 1'b0;
    pending_d   = '0;

    if (out_valid_q && result_ready) begin
      tbl_d[out_q.id] = ST_FREE;
      out_valid_d     = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end

    if (track_s) begin
      err_set_s             = (tbl_d[issue_req_id] != ST_FREE);
      tbl_d[issue_req_id]   = ST_ISSUED;
    end else begin
      err_set_s = 1'b0;
    end

    // Commit sees the post-track state so a same-cycle track+commit resolves cleanly.
    if (commit_valid) begin
      if (tbl_d[commit_id] == ST_ISSUED) begin
        tbl_d[commit_id] = commit_kill ? ST_KILLED : ST_COMMITTED;
      end else begin
        err_set_s = 1'b1;
      end
    end else begin
      err_set_s = err_set_s;
    end

    head_st_s = tbl_d[head_s.id];
    in_st_s   = tbl_d[cp_result_id];

`ifdef COPROC_RESULT_GATE_BYPASS_EN
    bypass_s = fifo_empty_s & out_room_s &
               ((in_st_s == ST_COMMITTED) | (in_st_s == ST_KILLED));
`else
    bypass_s = 1'b0;
`endif

    if (cp_wr_s) begin
      if (in_st_s == ST_FREE) begin
        err_set_s = 1'b1;
      end else if (bypass_s) begin
        if (in_st_s == ST_COMMITTED) begin
          load_s_en = 1'b1;
          load_s    = cp_res_s;
        end else begin
          tbl_d[cp_result_id] = ST_FREE;
        end
      end else begin
        mem_d[wr_ptr_q[AW-1:0]] = cp_res_s;
        wr_ptr_d                = wr_ptr_q + {{AW{1'b0}}, 1'b1};
      end
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    // Head state already includes this cycle's commit, giving commit-to-valid latency of one.
    if (!fifo_empty_s) begin
      case (head_st_s)
        ST_KILLED: begin
          rd_ptr_d          = rd_ptr_q + {{AW{1'b0}}, 1'b1};
          tbl_d[head_s.id]  = ST_FREE;
        end
        ST_COMMITTED: begin
          if (out_room_s) begin
            rd_ptr_d  = rd_ptr_q + {{AW{1'b0}}, 1'b1};
            load_s_en = 1'b1;
            load_s    = head_s;
          end else begin
            rd_ptr_d = rd_ptr_q;
          end
        end
        default: rd_ptr_d = rd_ptr_q;
      endcase
    end else begin
      rd_ptr_d = rd_ptr_q;
    end

    if (load_s_en) begin
      out_valid_d = 1'b1;
      out_d       = load_s;
    end else begin
      out_d = out_q;
    end

    for (int i = 0; i < NUM_IDS; i++) begin
      pending_d = pending_d + {{X_ID_WIDTH{1'b0}}, (tbl_d[i] != ST_FREE)};
    end
    err_d = err_q | err_set_s;
  end

  // State registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NUM_IDS; i++) tbl_q[i] <= ST_FREE;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      out_valid_q <= 1'b0;
      out_q       <= '0;
      pending_q   <= '0;
      err_q       <= 1'b0;
    end else begin
      tbl_q       <= tbl_d;
      mem_q       <= mem_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      out_valid_q <= out_valid_d;
      out_q       <= out_d;
      pending_q   <= pending_d;
      err_q       <= err_d;
    end
  end

  assign cp_result_ready = ~fifo_full_s;
  assign result_valid    = out_valid_q;
  assign result_id       = out_q.id;
  assign result_data     = out_q.data;
  assign result_rd       = out_q.rd;
  assign result_we       = out_q.we;
  assign result_exc      = out_q.exc;
  assign result_exccode  = out_q.exccode;
  assign pending_count   = pending_q;
  assign err_o           = err_q;

endmodule

// File: tb/tb_coproc_result_gate.sv
// Directed bench for coproc_result_gate; latency expectations follow COPROC_RESULT_GATE_BYPASS_EN.
module tb_coproc_result_gate;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        issue_valid, issue_ready, issue_resp_accept, issue_resp_writeback;
  logic [3:0]  issue_req_id;
  logic        commit_valid, commit_kill;
  logic [3:0]  commit_id;
  logic        cp_result_valid, cp_result_ready;
  logic [3:0]  cp_result_id;
  logic [31:0] cp_result_data;
  logic [4:0]  cp_result_rd;
  logic [0:0]  cp_result_we;
  logic        cp_result_exc;
  logic [5:0]  cp_result_exccode;
  logic        result_valid, result_ready;
  logic [3:0]  result_id;
  logic [31:0] result_data;
  logic [4:0]  result_rd;
  logic [0:0]  result_we;
  logic        result_exc;
  logic [5:0]  result_exccode;
  logic [4:0]  pending_count;
  logic        err_o;

  int checks = 0;
  int errors = 0;
  logic [3:0]  got_id[$];
  logic [31:0] got_data[$];

  coproc_result_gate dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .issue_valid(issue_valid), .issue_ready(issue_ready),
    .issue_resp_accept(issue_resp_accept), .issue_resp_writeback(issue_resp_writeback),
    .issue_req_id(issue_req_id),
    .commit_valid(commit_valid), .commit_id(commit_id), .commit_kill(commit_kill),
    .cp_result_valid(cp_result_valid), .cp_result_ready(cp_result_ready),
    .cp_result_id(cp_result_id), .cp_result_data(cp_result_data), .cp_result_rd(cp_result_rd),
    .cp_result_we(cp_result_we), .cp_result_exc(cp_result_exc), .cp_result_exccode(cp_result_exccode),
    .result_valid(result_valid), .result_ready(result_ready),
    .result_id(result_id), .result_data(result_data), .result_rd(result_rd),
    .result_we(result_we), .result_exc(result_exc), .result_exccode(result_exccode),
    .pending_count(pending_count), .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      $error("check %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_track(input logic [3:0] id);
    issue_valid = 1'b1; issue_ready = 1'b1; issue_resp_accept = 1'b1;
    issue_resp_writeback = 1'b1; issue_req_id = id;
  endtask

  task automatic set_commit(input logic [3:0] id, input logic kill);
    commit_valid = 1'b1; commit_id = id; commit_kill = kill;
  endtask

  task automatic set_result(input logic [3:0] id, input logic [31:0] data, input logic [4:0] rd);
    cp_result_valid = 1'b1; cp_result_id = id; cp_result_data = data;
    cp_result_rd = rd; cp_result_we = 1'b1; cp_result_exc = 1'b0; cp_result_exccode = 6'd0;
  endtask

  task automatic clear_pulses();
    issue_valid = 1'b0; commit_valid = 1'b0; cp_result_valid = 1'b0;
  endtask

  initial begin
    rst_ni = 1'b0; result_ready = 1'b0;
    issue_ready = 1'b0; issue_resp_accept = 1'b0; issue_resp_writeback = 1'b0;
    issue_req_id = 4'd0; commit_id = 4'd0; commit_kill = 1'b0;
    cp_result_id = 4'd0; cp_result_data = 32'd0; cp_result_rd = 5'd0;
    cp_result_we = 1'b0; cp_result_exc = 1'b0; cp_result_exccode = 6'd0;
    clear_pulses();
    repeat (2) @(posedge clk_i);
    #1;
    check("rst_valid", result_valid, 1'b0);
    check("rst_data", result_data, 32'd0);
    check("rst_cp_ready", cp_result_ready, 1'b1);
    check("rst_pending", pending_count, 5'd0);
    check("rst_err", err_o, 1'b0);
    rst_ni = 1'b1;
    tick();

    // Committed-before-result path
    set_track(4'd3); tick(); clear_pulses();
    check("t1_pending_up", pending_count, 5'd1);
    set_commit(4'd3, 1'b0); tick(); clear_pulses();
    set_result(4'd3, 32'hDEADBEEF, 5'd5); tick(); clear_pulses();
`ifndef COPROC_RESULT_GATE_BYPASS_EN
    check("t1_not_early", result_valid, 1'b0);
    tick();
`endif
    check("t1_valid", result_valid, 1'b1);
    check("t1_id", result_id, 4'd3);
    check("t1_data", result_data, 32'hDEADBEEF);
    check("t1_rd", result_rd, 5'd5);
    tick();
    check("t1_hold_valid", result_valid, 1'b1);
    check("t1_hold_data", result_data, 32'hDEADBEEF);
    result_ready = 1'b1; tick(); result_ready = 1'b0;
    check("t1_empty", result_valid, 1'b0);
    check("t1_pending_down", pending_count, 5'd0);

    // Result waits at the head for a late commit
    set_track(4'd1); tick(); clear_pulses();
    set_result(4'd1, 32'h11, 5'd2); tick(); clear_pulses();
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t2_blocked", result_valid, 1'b0);
    end
    set_commit(4'd1, 1'b0); tick(); clear_pulses();
    check("t2_valid", result_valid, 1'b1);
    check("t2_id", result_id, 4'd1);
    check("t2_data", result_data, 32'h11);
    result_ready = 1'b1; tick(); result_ready = 1'b0;
    check("t2_empty", result_valid, 1'b0);
    check("t2_pending", pending_count, 5'd0);

    // Killed ID: result silently discarded
    set_track(4'd2); tick(); clear_pulses();
    set_commit(4'd2, 1'b1); tick(); clear_pulses();
    set_result(4'd2, 32'h22, 5'd3); tick(); clear_pulses();
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t3_no_valid", result_valid, 1'b0);
    end
    check("t3_pending", pending_count, 5'd0);
    check("t3_err", err_o, 1'b0);

    // Fill FIFO with uncommitted results, then drain in order
    for (int i = 0; i < 5; i++) begin
      set_track(4'(i)); tick(); clear_pulses();
    end
    check("t4_pending5", pending_count, 5'd5);
    for (int i = 0; i < 4; i++) begin
      check("t4_ready_before", cp_result_ready, 1'b1);
      set_result(4'(i), 32'h100 + 32'(i), 5'(i)); tick(); clear_pulses();
    end
    check("t4_full", cp_result_ready, 1'b0);
    check("t4_hol_blocked", result_valid, 1'b0);
    result_ready = 1'b1;
    for (int c = 0; c < 20; c++) begin
      if (c < 4) set_commit(4'(c), 1'b0);
      tick(); clear_pulses();
      if (result_valid) begin
        got_id.push_back(result_id);
        got_data.push_back(result_data);
      end
    end
    check("t4_count", got_id.size(), 4);
    for (int i = 0; i < got_id.size(); i++) begin
      check("t4_order_id", got_id[i], 4'(i));
      check("t4_order_data", got_data[i], 32'h100 + 32'(i));
    end
    check("t4_ready_again", cp_result_ready, 1'b1);
    set_result(4'd4, 32'h104, 5'd4); tick(); clear_pulses();
    set_commit(4'd4, 1'b1); tick(); clear_pulses();
    tick();
    check("t4_kill_no_valid", result_valid, 1'b0);
    check("t4_pending0", pending_count, 5'd0);
    check("t4_err", err_o, 1'b0);
    result_ready = 1'b0;

    // Same-cycle track and commit
    set_track(4'd6); set_commit(4'd6, 1'b0); tick(); clear_pulses();
    check("t6_pending", pending_count, 5'd1);
    check("t6_err", err_o, 1'b0);
    set_result(4'd6, 32'h66, 5'd6); tick(); clear_pulses();
    check("t6_pending_peak", pending_count, 5'd1);
`ifndef COPROC_RESULT_GATE_BYPASS_EN
    tick();
`endif
    check("t6_valid", result_valid, 1'b1);
    check("t6_id", result_id, 4'd6);
    check("t6_data", result_data, 32'h66);
    result_ready = 1'b1; tick(); result_ready = 1'b0;
    check("t6_empty", result_valid, 1'b0);
    check("t6_pending0", pending_count, 5'd0);

    // Protocol errors and asynchronous reset
    set_result(4'd7, 32'h77, 5'd7); tick(); clear_pulses();
    check("t5_err_untracked", err_o, 1'b1);
    check("t5_dropped", result_valid, 1'b0);
    set_commit(4'd9, 1'b0); tick(); clear_pulses();
    check("t5_err_sticky", err_o, 1'b1);
    set_track(4'd5); tick(); clear_pulses();
    set_commit(4'd5, 1'b0); tick(); clear_pulses();
    set_result(4'd5, 32'h55, 5'd1); tick(); clear_pulses();
    tick();
    check("t5_pre_rst_valid", result_valid, 1'b1);
    rst_ni = 1'b0;
    #1;
    check("t5_rst_err", err_o, 1'b0);
    check("t5_rst_valid", result_valid, 1'b0);
    check("t5_rst_pending", pending_count, 5'd0);
    tick();
    rst_ni = 1'b1;
    tick();
    check("t5_post_rst_ready", cp_result_ready, 1'b1);
    check("t5_post_rst_valid", result_valid, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
